// File: rtl/jump_hazard_ctrl.sv
// Fetch-stage hazard controller: holds the PC on load-use and on unresolved
// branches/jumps, then presents the redirect target for exactly one cycle.
module jump_hazard_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk_pc,
   input  logic             rst_pc,
   input  logic             id_valid,
   input  logic             id_is_ctrl,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             ex_resolve,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   output logic             pipline_stop,
   output logic             pipline_stop_jump,
   output logic [XLEN-1:0]  din,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             timeout_err,
   output logic [CNT_W-1:0] ld_stall_cnt,
   output logic [CNT_W-1:0] jmp_stall_cnt
);

   localparam int WCW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, JWAIT, REDIRECT} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  din_q, din_d;
   logic [XLEN-1:0]  fallback_q, fallback_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             terr_q, terr_d;
   logic [CNT_W-1:0] ldCnt_q, ldCnt_d;
   logic [CNT_W-1:0] jmpCnt_q, jmpCnt_d;

   logic             loadUse;
   logic [XLEN-1:0]  idPcPlus4;
   logic             stop, stopJump, flushIfid, flushIdex;

   assign loadUse = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

   // Wraps modulo 2^XLEN by construction.
   assign idPcPlus4 = id_pc + XLEN'(4);

   // Next-state and combinational hazard outputs; load-use only matters in IDLE.
   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      fallback_d = fallback_q;
      wcnt_d     = wcnt_q;
      terr_d     = terr_q;
      stop       = 1'b0;
      stopJump   = 1'b0;
      flushIfid  = 1'b0;
      flushIdex  = 1'b0;
      case (state_q)
         IDLE: begin
            if (loadUse) begin
               stop      = 1'b1;
               flushIdex = 1'b1;
            end else if (id_valid && id_is_ctrl) begin
               stopJump   = 1'b1;
               fallback_d = idPcPlus4;
               wcnt_d     = '0;
               if (ex_resolve) begin
                  din_d   = ex_taken ? ex_target : idPcPlus4;
                  state_d = REDIRECT;
               end else begin
                  state_d = JWAIT;
               end
            end
         end
         JWAIT: begin
            stopJump  = 1'b1;
            flushIdex = 1'b1;
            if (ex_resolve) begin
               din_d   = ex_taken ? ex_target : fallback_q;
               state_d = REDIRECT;
            end else if (wcnt_q + WCW'(1) == WCW'(TIMEOUT - 1)) begin
               din_d   = fallback_q;
               terr_d  = 1'b1;
               state_d = REDIRECT;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         REDIRECT: begin
            flushIfid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Quiet the hold/flush lines while reset is asserted, without waiting for an edge.
      if (rst_pc) begin
         stop      = 1'b0;
         stopJump  = 1'b0;
         flushIfid = 1'b0;
         flushIdex = 1'b0;
      end
   end

   always_comb begin
      ldCnt_d  = (stop && (ldCnt_q != '1)) ? ldCnt_q + CNT_W'(1) : ldCnt_q;
      jmpCnt_d = (stopJump && (jmpCnt_q != '1)) ? jmpCnt_q + CNT_W'(1) : jmpCnt_q;
   end

   always_ff @(posedge clk_pc or posedge rst_pc) begin
      if (rst_pc) begin
         state_q    <= IDLE;
         din_q      <= '0;
         fallback_q <= '0;
         wcnt_q     <= '0;
         terr_q     <= 1'b0;
         ldCnt_q    <= '0;
         jmpCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         din_q      <= din_d;
         fallback_q <= fallback_d;
         wcnt_q     <= wcnt_d;
         terr_q     <= terr_d;
         ldCnt_q    <= ldCnt_d;
         jmpCnt_q   <= jmpCnt_d;
      end
   end

   assign pipline_stop      = stop;
   assign pipline_stop_jump = stopJump;
   assign flush_ifid        = flushIfid;
   assign flush_idex        = flushIdex;
   assign din               = din_q;
   assign timeout_err       = terr_q;
   assign ld_stall_cnt      = ldCnt_q;
   assign jmp_stall_cnt     = jmpCnt_q;

endmodule

// File: tb/tb_jump_hazard_ctrl.sv
// Self-checking bench for jump_hazard_ctrl: directed scenarios plus random
// traffic, all compared every cycle against a cycle-count reference model.
module tb_jump_hazard_ctrl;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk_pc = 1'b0;
   logic             rst_pc;
   logic             id_valid, id_is_ctrl;
   logic [XLEN-1:0]  id_pc;
   logic [4:0]       id_rs1, id_rs2;
   logic             id_use_rs1, id_use_rs2;
   logic             ex_is_load;
   logic [4:0]       ex_rd;
   logic             ex_resolve, ex_taken;
   logic [XLEN-1:0]  ex_target;
   logic             pipline_stop, pipline_stop_jump;
   logic [XLEN-1:0]  din;
   logic             flush_ifid, flush_idex, timeout_err;
   logic [CNT_W-1:0] ld_stall_cnt, jmp_stall_cnt;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: a jump outstanding for mHeld hold cycles, or a redirect due now.
   bit              mBusy, mRedir, mErr;
   int              mHeld, mLd, mJmp;
   logic [XLEN-1:0] mFallback, mDin;

   jump_hazard_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_pc(clk_pc), .rst_pc(rst_pc),
      .id_valid(id_valid), .id_is_ctrl(id_is_ctrl), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
      .pipline_stop(pipline_stop), .pipline_stop_jump(pipline_stop_jump),
      .din(din), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .timeout_err(timeout_err),
      .ld_stall_cnt(ld_stall_cnt), .jmp_stall_cnt(jmp_stall_cnt)
   );

   always #5 clk_pc = ~clk_pc;

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                              input logic [XLEN-1:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mRedir = 0; mErr = 0; mHeld = 0;
      mLd = 0; mJmp = 0; mFallback = '0; mDin = '0;
   endtask

   task automatic setIdle();
      id_valid = 0; id_is_ctrl = 0; id_pc = '0;
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_is_load = 0; ex_rd = '0; ex_resolve = 0; ex_taken = 0; ex_target = '0;
   endtask

   // Entered just after a rising edge with inputs set; checks at the falling edge.
   task automatic applyStimulus();
      bit lu, eStop, eJump, eIfid, eIdex;
      @(negedge clk_pc);
      lu = id_valid && ex_is_load && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      eStop = 0; eJump = 0; eIfid = 0; eIdex = 0;
      if (mRedir) eIfid = 1;
      else if (mBusy) begin eJump = 1; eIdex = 1; end
      else if (lu) begin eStop = 1; eIdex = 1; end
      else if (id_valid && id_is_ctrl) eJump = 1;

      checkOutput("stop",       XLEN'(pipline_stop),      XLEN'(eStop));
      checkOutput("stop_jump",  XLEN'(pipline_stop_jump), XLEN'(eJump));
      checkOutput("flush_ifid", XLEN'(flush_ifid),        XLEN'(eIfid));
      checkOutput("flush_idex", XLEN'(flush_idex),        XLEN'(eIdex));
      checkOutput("din",        din,                      mDin);
      checkOutput("timeout",    XLEN'(timeout_err),       XLEN'(mErr));
      checkOutput("ld_cnt",     XLEN'(ld_stall_cnt),      XLEN'(mLd));
      checkOutput("jmp_cnt",    XLEN'(jmp_stall_cnt),     XLEN'(mJmp));

      if (eStop) mLd  = (mLd  < CMAX) ? mLd  + 1 : CMAX;
      if (eJump) mJmp = (mJmp < CMAX) ? mJmp + 1 : CMAX;
      if (mRedir) mRedir = 0;
      else if (mBusy) begin
         mHeld++;
         if (ex_resolve) begin
            mDin = ex_taken ? ex_target : mFallback;
            mBusy = 0; mRedir = 1;
         end else if (mHeld == TIMEOUT) begin
            mDin = mFallback; mErr = 1;
            mBusy = 0; mRedir = 1;
         end
      end else if (!lu && id_valid && id_is_ctrl) begin
         mFallback = id_pc + 4;
         mHeld = 1;
         if (ex_resolve) begin
            mDin = ex_taken ? ex_target : mFallback;
            mRedir = 1;
         end else mBusy = 1;
      end
      @(posedge clk_pc);
      #1;
   endtask

   // Branch in ID for one cycle, resolved after resolveDelay further cycles (<0: never).
   task automatic jumpSeq(input logic [XLEN-1:0] pc, input int resolveDelay,
                          input bit taken, input logic [XLEN-1:0] target, input int extra);
      setIdle();
      id_valid = 1; id_is_ctrl = 1; id_pc = pc;
      ex_resolve = (resolveDelay == 0); ex_taken = taken; ex_target = target;
      applyStimulus();
      for (int i = 1; i <= extra; i++) begin
         setIdle();
         if (i == resolveDelay) begin
            ex_resolve = 1; ex_taken = taken; ex_target = target;
         end
         applyStimulus();
      end
      setIdle();
   endtask

   task automatic asyncResetPulse();
      rst_pc = 1;
      #1;
      checkOutput("rst_stop",  XLEN'(pipline_stop),      '0);
      checkOutput("rst_jump",  XLEN'(pipline_stop_jump), '0);
      checkOutput("rst_ifid",  XLEN'(flush_ifid),        '0);
      checkOutput("rst_idex",  XLEN'(flush_idex),        '0);
      checkOutput("rst_din",   din,                      '0);
      checkOutput("rst_terr",  XLEN'(timeout_err),       '0);
      checkOutput("rst_ldcnt", XLEN'(ld_stall_cnt),      '0);
      checkOutput("rst_jpcnt", XLEN'(jmp_stall_cnt),     '0);
      modelReset();
      #1 rst_pc = 0;
      @(posedge clk_pc);
      #1;
   endtask

   initial begin
      rst_pc = 1;
      setIdle();
      modelReset();
      #3;
      checkOutput("reset_din",   din,                 '0);
      checkOutput("reset_terr",  XLEN'(timeout_err),  '0);
      checkOutput("reset_ldcnt", XLEN'(ld_stall_cnt), '0);
      @(posedge clk_pc);
      #1 rst_pc = 0;
      applyStimulus();

      // Load-use, then the same with x0 as destination, then load-use masking a branch.
      ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_valid = 1;
      applyStimulus();
      ex_rd = 0; id_rs1 = 0;
      applyStimulus();
      setIdle();
      ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_valid = 1;
      id_is_ctrl = 1; id_pc = 32'h40;
      applyStimulus();
      setIdle();
      applyStimulus();

      // Taken, not-taken, same-cycle resolve, PC wrap, then timeout.
      jumpSeq(32'h40, 2, 1, 32'h100, 4);
      jumpSeq(32'h40, 2, 0, 32'h100, 4);
      jumpSeq(32'h200, 0, 1, 32'h80, 2);
      jumpSeq(32'hFFFF_FFFC, 1, 0, 32'h1234, 3);
      jumpSeq(32'h500, -1, 0, 32'h0, TIMEOUT + 2);
      checkOutput("timeout_sticky", XLEN'(timeout_err), 32'd1);
      checkOutput("timeout_din",    din,                32'h504);

      // Reset pulse while waiting in JWAIT.
      jumpSeq(32'h600, -1, 0, 32'h0, 2);
      asyncResetPulse();

      // Random traffic with small register ranges to provoke hazards.
      for (int c = 0; c < 3000; c++) begin
         id_valid   = ($urandom_range(0, 9) < 7);
         id_is_ctrl = ($urandom_range(0, 9) < 3);
         id_pc      = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         id_rs1     = 5'($urandom_range(0, 3));
         id_rs2     = 5'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom());
         id_use_rs2 = 1'($urandom());
         ex_is_load = ($urandom_range(0, 9) < 4);
         ex_rd      = 5'($urandom_range(0, 3));
         ex_resolve = ($urandom_range(0, 9) < 2);
         ex_taken   = 1'($urandom());
         ex_target  = $urandom();
         applyStimulus();
         if (c % 700 == 699) begin
            setIdle();
            asyncResetPulse();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
